// File: rtl/led_controller_pkg.sv
// Shared register map, reset values and access-FSM encoding for led_controller.
package led_controller_pkg;

    localparam logic [31:0] OFF_DATA   = 32'h00;
    localparam logic [31:0] OFF_MASK   = 32'h04;
    localparam logic [31:0] OFF_PERIOD = 32'h08;
    localparam logic [31:0] OFF_STATUS = 32'h0C;
    localparam logic [31:0] OFF_BRIGHT = 32'h10;

    // Only address bits [4:2] select a register.
    localparam logic [2:0] IDX_DATA   = OFF_DATA[4:2];
    localparam logic [2:0] IDX_MASK   = OFF_MASK[4:2];
    localparam logic [2:0] IDX_PERIOD = OFF_PERIOD[4:2];
    localparam logic [2:0] IDX_STATUS = OFF_STATUS[4:2];
    localparam logic [2:0] IDX_BRIGHT = OFF_BRIGHT[4:2];

    localparam logic [31:0] RST_DATA   = 32'h0;
    localparam logic [31:0] RST_MASK   = 32'h0;
    localparam logic [15:0] RST_PERIOD = 16'h0;
    localparam logic [7:0]  RST_BRIGHT = 8'hFF;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACK     = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

endpackage

// File: rtl/led_blink_timer.sv
// Prescaler, blink period counter and phase flag; restart clears all three.
module led_blink_timer #(
    parameter int PRESCALE = 1000
) (
    input  logic        i_clock,
    input  logic        i_reset_n,
    input  logic [15:0] period,
    input  logic        restart,
    output logic        phase,
    output logic [15:0] count
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] presc_q, presc_d;
    logic [15:0]   count_q, count_d;
    logic          phase_q, phase_d;
    logic          tick;

    always_comb begin
        tick    = (presc_q == PRESCALE_LAST);
        presc_d = tick ? '0 : presc_q + 1'b1;
        count_d = count_q;
        phase_d = phase_q;
        if (restart) begin
            presc_d = '0;
            count_d = '0;
            phase_d = 1'b0;
        end else if (period == 16'd0) begin
            count_d = '0;
            phase_d = 1'b0;
        end else if (tick) begin
            if (count_q == period - 16'd1) begin
                count_d = '0;
                phase_d = ~phase_q;
            end else begin
                count_d = count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            presc_q <= '0;
            count_q <= '0;
            phase_q <= 1'b0;
        end else begin
            presc_q <= presc_d;
            count_q <= count_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;
    assign count = count_q;

endmodule

// File: rtl/led_controller.sv
// Bus-mapped LED driver with blinking; define LED_CONTROLLER_PWM_EN to add
// the BRIGHTNESS register and PWM dimming of o_leds.
module led_controller
    import led_controller_pkg::*;
#(
    parameter int PRESCALE  = 1000,
    parameter int LED_COUNT = 10
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_request,
    input  logic                 i_rw,
    input  logic [31:0]          i_address,
    input  logic [31:0]          i_wdata,
    output logic [31:0]          o_rdata,
    output logic                 o_ready,
    output logic [LED_COUNT-1:0] o_leds
);

    state_e               state_q, state_d;
    logic [LED_COUNT-1:0] data_q, data_d, mask_q, mask_d, leds_q, leds_d;
    logic [15:0]          period_q, period_d;
    logic                 ready_q, ready_d;
    logic [31:0]          rdata_q, rdata_d, rd_val;
    logic                 period_wr, phase;
    logic [15:0]          count;
    logic [2:0]           sel;
    logic                 unused_bits;
`ifdef LED_CONTROLLER_PWM_EN
    logic [7:0]           bright_q, bright_d, pwm_q, pwm_d;
`endif

    assign sel         = i_address[4:2];
    assign unused_bits = ^{i_address[31:5], i_address[1:0], i_wdata};

    led_blink_timer #(.PRESCALE(PRESCALE)) u_timer (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .period    (period_q),
        .restart   (period_wr),
        .phase     (phase),
        .count     (count)
    );

    always_comb begin
        case (sel)
            IDX_DATA:   rd_val = 32'(data_q);
            IDX_MASK:   rd_val = 32'(mask_q);
            IDX_PERIOD: rd_val = 32'(period_q);
            IDX_STATUS: rd_val = {count, 15'd0, phase};
`ifdef LED_CONTROLLER_PWM_EN
            IDX_BRIGHT: rd_val = 32'(bright_q);
`endif
            default:    rd_val = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        mask_d    = mask_q;
        period_d  = period_q;
        ready_d   = 1'b0;
        rdata_d   = rdata_q;
        period_wr = 1'b0;
`ifdef LED_CONTROLLER_PWM_EN
        bright_d  = bright_q;
`endif
        case (state_q)
            ST_IDLE: if (i_request) state_d = ST_ACK;
            ST_ACK: begin
                ready_d = 1'b1;
                state_d = ST_RELEASE;
                if (i_rw) begin
                    rdata_d = '0;
                    case (sel)
                        IDX_DATA:   data_d = i_wdata[LED_COUNT-1:0];
                        IDX_MASK:   mask_d = i_wdata[LED_COUNT-1:0];
                        IDX_PERIOD: begin
                            period_d  = i_wdata[15:0];
                            period_wr = 1'b1;
                        end
`ifdef LED_CONTROLLER_PWM_EN
                        IDX_BRIGHT: bright_d = i_wdata[7:0];
`endif
                        default: ;
                    endcase
                end else begin
                    rdata_d = rd_val;
                end
            end
            ST_RELEASE: if (!i_request) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        leds_d = data_q ^ (mask_q & {LED_COUNT{phase}});
`ifdef LED_CONTROLLER_PWM_EN
        pwm_d = pwm_q + 8'd1;
        if (pwm_q >= bright_q) leds_d = '0;
`endif
    end

    always_ff @(posedge i_clock) begin
        if (!i_reset_n) begin
            state_q  <= ST_IDLE;
            data_q   <= LED_COUNT'(RST_DATA);
            mask_q   <= LED_COUNT'(RST_MASK);
            period_q <= RST_PERIOD;
            ready_q  <= 1'b0;
            rdata_q  <= '0;
            leds_q   <= '0;
`ifdef LED_CONTROLLER_PWM_EN
            bright_q <= RST_BRIGHT;
            pwm_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            mask_q   <= mask_d;
            period_q <= period_d;
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            leds_q   <= leds_d;
`ifdef LED_CONTROLLER_PWM_EN
            bright_q <= bright_d;
            pwm_q    <= pwm_d;
`endif
        end
    end

    assign o_ready = ready_q;
    assign o_rdata = rdata_q;
    assign o_leds  = leds_q;

endmodule

// File: tb/tb_led_controller.sv
// Self-checking bench for led_controller: randomized bus traffic against an
// arithmetic model of the blink timing (phase derived from elapsed cycles).
module tb_led_controller;

    localparam int PRESCALE  = 4;
    localparam int LED_COUNT = 10;
    localparam logic [31:0] LMASK = (32'd1 << LED_COUNT) - 32'd1;

    logic                 clk = 1'b0;
    logic                 i_reset_n = 1'b0;
    logic                 i_request = 1'b0;
    logic                 i_rw = 1'b0;
    logic [31:0]          i_address = '0;
    logic [31:0]          i_wdata = '0;
    logic [31:0]          o_rdata;
    logic                 o_ready;
    logic [LED_COUNT-1:0] o_leds;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_ack = 0;

    // Model state: register contents plus the edges at which timers restarted.
    logic [31:0] m_data, m_mask;
    int          m_period, m_t0, m_rst, m_bright;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    led_controller #(.PRESCALE(PRESCALE), .LED_COUNT(LED_COUNT)) dut (
        .i_clock   (clk),
        .i_reset_n (i_reset_n),
        .i_request (i_request),
        .i_rw      (i_rw),
        .i_address (i_address),
        .i_wdata   (i_wdata),
        .o_rdata   (o_rdata),
        .o_ready   (o_ready),
        .o_leds    (o_leds)
    );

    // State after edge n: ticks elapsed since restart, split into half-periods.
    function automatic int phase_at(int n);
        if (m_period == 0) return 0;
        return (((n - m_t0) / PRESCALE) / m_period) % 2;
    endfunction

    function automatic int count_at(int n);
        if (m_period == 0) return 0;
        return ((n - m_t0) / PRESCALE) % m_period;
    endfunction

    function automatic logic [31:0] exp_leds(int n);
        logic [31:0] v;
        v = (m_data ^ (phase_at(n - 1) != 0 ? m_mask : 32'd0)) & LMASK;
`ifdef LED_CONTROLLER_PWM_EN
        if (((n - 1 - m_rst) % 256) >= m_bright) v = 32'd0;
`endif
        return v;
    endfunction

    function automatic logic [31:0] exp_read(logic [31:0] addr, int n);
        logic [15:0] c;
        c = 16'(count_at(n));
        case (addr[4:2])
            3'd0: return m_data;
            3'd1: return m_mask;
            3'd2: return 32'(m_period);
            3'd3: return {c, 15'd0, phase_at(n) != 0};
`ifdef LED_CONTROLLER_PWM_EN
            3'd4: return 32'(m_bright);
`endif
            default: return 32'd0;
        endcase
    endfunction

    function automatic void model_write(logic [31:0] addr, logic [31:0] wd, int edge_n);
        case (addr[4:2])
            3'd0: m_data = wd & LMASK;
            3'd1: m_mask = wd & LMASK;
            3'd2: begin m_period = int'(wd[15:0]); m_t0 = edge_n; end
`ifdef LED_CONTROLLER_PWM_EN
            3'd4: m_bright = int'(wd[7:0]);
`endif
            default: ;
        endcase
    endfunction

    function automatic void model_reset(int edge_n);
        m_data = 0; m_mask = 0; m_period = 0; m_bright = 255;
        m_t0 = edge_n; m_rst = edge_n;
    endfunction

    // Called at a sample point with the FSM idle; returns one edge after release.
    task automatic bus_xfer(input logic rw, input logic [31:0] addr, input logic [31:0] wd,
                            output logic [31:0] rd, output int lat);
        int   waited = 0;
        logic got = 1'b0;
        i_request = 1'b1; i_rw = rw; i_address = addr; i_wdata = wd;
        while (!got && waited < 8) begin
            @(posedge clk); #1;
            waited++;
            if (o_ready === 1'b1) got = 1'b1;
        end
        lat = got ? waited : -1;
        if (!got) begin
            tests++; fails++;
            $display("FAIL bus_timeout addr=%h: no o_ready within %0d cycles", addr, waited);
        end
        rd = o_rdata;
        last_ack = cyc;
        if (got && rw) model_write(addr, wd, cyc);
        $display("[TB] %s addr=%h wdata=%h rdata=%h latency=%0d", rw ? "WR" : "RD", addr, wd, rd, lat);
        i_request = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0; i_request = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        model_reset(cyc);
        i_reset_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [31:0] rd; int lat;
        logic [31:0] addrs [4];
        addrs = '{32'h0, 32'h4, 32'h8, 32'hC};
        do_reset();
        tests++; if (o_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b want=0", o_ready); end
        tests++; if (o_rdata !== 32'd0) begin fails++; $display("FAIL reset_rdata got=%h want=0", o_rdata); end
        tests++; if (o_leds !== '0) begin fails++; $display("FAIL reset_leds got=%h want=0", o_leds); end
        foreach (addrs[i]) begin
            bus_xfer(1'b0, addrs[i], 32'd0, rd, lat);
            tests++;
            if (rd !== exp_read(addrs[i], last_ack - 1)) begin
                fails++; $display("FAIL reset_read addr=%h got=%h want=%h", addrs[i], rd, exp_read(addrs[i], last_ack - 1));
            end
        end
    endtask

    task automatic test_data_write();
        logic [31:0] rd; int lat;
        bus_xfer(1'b1, 32'h0, 32'h2AA, rd, lat);
        tests++; if (lat != 2) begin fails++; $display("FAIL write_latency got=%0d want=2", lat); end
        tests++;
        if (o_leds !== exp_leds(cyc)[LED_COUNT-1:0] || exp_leds(cyc) != 32'h2AA) begin
            fails++; $display("FAIL write_leds got=%h want=%h", o_leds, 32'h2AA);
        end
        bus_xfer(1'b0, 32'h0, 32'd0, rd, lat);
        tests++; if (rd !== 32'h0000_02AA) begin fails++; $display("FAIL data_readback got=%h want=000002aa", rd); end
    endtask

    task automatic test_blink();
        logic [31:0] rd; int lat, last_chg, changes;
        logic [LED_COUNT-1:0] prev;
        bus_xfer(1'b1, 32'h0, 32'h0, rd, lat);
        bus_xfer(1'b1, 32'h4, 32'h3FF, rd, lat);
        bus_xfer(1'b1, 32'h8, 32'd3, rd, lat);
        last_chg = -1; changes = 0; prev = o_leds;
        repeat (60) begin
            @(posedge clk); #1;
            tests++;
            if (o_leds !== exp_leds(cyc)[LED_COUNT-1:0]) begin
                fails++; $display("FAIL blink_leds cycle=%0d got=%h want=%h", cyc, o_leds, exp_leds(cyc));
            end
            if (o_leds !== prev) begin
                changes++;
`ifndef LED_CONTROLLER_PWM_EN
                if (last_chg >= 0) begin
                    tests++;
                    if (cyc - last_chg != 12) begin fails++; $display("FAIL blink_interval got=%0d want=12", cyc - last_chg); end
                end
`endif
                last_chg = cyc; prev = o_leds;
            end
        end
`ifndef LED_CONTROLLER_PWM_EN
        tests++; if (changes < 4) begin fails++; $display("FAIL blink_toggles got=%0d want>=4", changes); end
`endif
    endtask

    task automatic test_period_zero();
        logic [31:0] rd; int lat;
        bus_xfer(1'b1, 32'h8, 32'd3, rd, lat);
        repeat (17) @(posedge clk);
        #1;
        bus_xfer(1'b1, 32'h8, 32'd0, rd, lat);
        bus_xfer(1'b1, 32'h0, 32'h0F0, rd, lat);
        repeat (50) begin
            @(posedge clk); #1;
            tests++;
            if (o_leds !== exp_leds(cyc)[LED_COUNT-1:0]) begin
                fails++; $display("FAIL period0_leds cycle=%0d got=%h want=%h", cyc, o_leds, exp_leds(cyc));
            end
        end
        bus_xfer(1'b0, 32'hC, 32'd0, rd, lat);
        tests++; if (rd !== 32'd0) begin fails++; $display("FAIL period0_status got=%h want=0", rd); end
    endtask

    task automatic test_hold_request();
        logic [31:0] rd, cap; int lat, pulses, first;
        logic [31:0] addrs [3];
        addrs = '{32'h0, 32'h4, 32'h8};
        i_request = 1'b1; i_rw = 1'b0; i_address = 32'h1C;
        pulses = 0; first = -1; cap = 32'hDEAD_BEEF;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            if (o_ready === 1'b1) begin pulses++; cap = o_rdata; if (first < 0) first = k; end
        end
        i_request = 1'b0;
        @(posedge clk); #1;
        $display("[TB] RD addr=0000001c held 10 cycles, ready pulses=%0d rdata=%h", pulses, cap);
        tests++; if (pulses != 1) begin fails++; $display("FAIL hold_pulses got=%0d want=1", pulses); end
        tests++; if (first != 2) begin fails++; $display("FAIL hold_latency got=%0d want=2", first); end
        tests++; if (cap !== 32'd0) begin fails++; $display("FAIL unmapped_read got=%h want=0", cap); end
        bus_xfer(1'b1, 32'h1C, 32'hFFFF_FFFF, rd, lat);
        foreach (addrs[i]) begin
            bus_xfer(1'b0, addrs[i], 32'd0, rd, lat);
            tests++;
            if (rd !== exp_read(addrs[i], last_ack - 1)) begin
                fails++; $display("FAIL unmapped_write addr=%h got=%h want=%h", addrs[i], rd, exp_read(addrs[i], last_ack - 1));
            end
        end
    endtask

    task automatic test_reset_during_ack();
        logic [31:0] rd; int lat, pulses;
        i_request = 1'b1; i_rw = 1'b1; i_address = 32'h0; i_wdata = 32'h155;
        @(posedge clk); #1;
        i_reset_n = 1'b0;
        pulses = 0;
        repeat (2) begin
            @(posedge clk); #1;
            if (o_ready !== 1'b0) pulses++;
        end
        i_request = 1'b0;
        @(posedge clk); #1;
        model_reset(cyc);
        i_reset_n = 1'b1;
        $display("[TB] WR addr=00000000 wdata=00000155 aborted by reset");
        tests++; if (pulses != 0) begin fails++; $display("FAIL abort_ready got=%0d pulses want=0", pulses); end
        tests++; if (o_leds !== '0) begin fails++; $display("FAIL abort_leds got=%h want=0", o_leds); end
        bus_xfer(1'b0, 32'h0, 32'd0, rd, lat);
        tests++; if (rd !== 32'd0) begin fails++; $display("FAIL abort_data got=%h want=0", rd); end
    endtask

    task automatic test_random();
        logic [31:0] rd, addr, wd; logic rw; int lat;
        for (int t = 0; t < 40; t++) begin
            addr = $urandom;
            rw   = 1'($urandom_range(0, 1));
            wd   = $urandom;
            if (addr[4:2] == 3'd2) wd = {wd[31:16], 16'($urandom_range(0, 5))};
            bus_xfer(rw, addr, wd, rd, lat);
            tests++; if (lat != 2) begin fails++; $display("FAIL rand_latency got=%0d want=2", lat); end
            if (!rw) begin
                tests++;
                if (rd !== exp_read(addr, last_ack - 1)) begin
                    fails++; $display("FAIL rand_read addr=%h got=%h want=%h", addr, rd, exp_read(addr, last_ack - 1));
                end
            end
            repeat ($urandom_range(0, 15)) begin
                @(posedge clk); #1;
                tests++;
                if (o_leds !== exp_leds(cyc)[LED_COUNT-1:0]) begin
                    fails++; $display("FAIL rand_leds cycle=%0d got=%h want=%h", cyc, o_leds, exp_leds(cyc));
                end
            end
        end
    endtask

`ifdef LED_CONTROLLER_PWM_EN
    task automatic test_pwm();
        logic [31:0] rd; int lat, high;
        bus_xfer(1'b1, 32'h4, 32'h0, rd, lat);
        bus_xfer(1'b1, 32'h10, 32'h40, rd, lat);
        bus_xfer(1'b1, 32'h0, 32'h1, rd, lat);
        high = 0;
        repeat (256) begin
            @(posedge clk); #1;
            if (o_leds[0] === 1'b1) high++;
        end
        tests++; if (high != 64) begin fails++; $display("FAIL pwm_duty got=%0d want=64", high); end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset(0);
        test_reset();
        test_data_write();
        test_blink();
        test_period_zero();
        test_hold_request();
        test_reset_during_ack();
        test_random();
`ifdef LED_CONTROLLER_PWM_EN
        test_pwm();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
